// File: rtl/lead1_pkg.sv
// Shared types and helpers for the leading-1 request scheduler.
package lead1_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // Upper bound on the request vector width that popcount accepts.
  localparam int unsigned MAX_N = 64;

  function automatic logic [7:0] popcount(input logic [MAX_N-1:0] vec);
    logic [7:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      cnt += {7'b0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/lead_1_index.sv
// Leading-1 picker: index of the highest set bit and a non-zero flag.
module lead_1_index #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] index,
  output logic                 valid
);

  localparam int unsigned W = $clog2(N);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) index = W'(i);
    end
  end

  assign valid = |vec;

endmodule

// File: rtl/lead1_req_scheduler.sv
// Sticky request collector feeding an MSB-first grant stage with valid/ready output.
module lead1_req_scheduler
  import lead1_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_in,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic [N-1:0] pending,
  output logic [W:0]   pending_cnt
);

  state_t       state, state_next;
  logic [N-1:0] pending_next;
  logic [N-1:0] sel_onehot;
  logic [W-1:0] sel_index;
  logic         any_pending;
  logic         load;

  lead_1_index #(.N(N)) u_lead (
    .vec   (pending),
    .index (sel_index),
    .valid (any_pending)
  );

  assign out_valid = (state == FULL);
  assign load      = (state == EMPTY) || out_ready;

  always_comb begin
    state_next = state;
    sel_onehot = '0;
    if (flush) begin
      state_next = EMPTY;
    end else if (load) begin
      if (any_pending) begin
        state_next            = FULL;
        sel_onehot[sel_index] = 1'b1;
      end else begin
        state_next = EMPTY;
      end
    end
    // A request on the bit being granted re-arms it rather than being absorbed.
    pending_next = flush ? req_in : ((pending & ~sel_onehot) | req_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      pending   <= '0;
      out_index <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (!flush && load && any_pending) out_index <= sel_index;
    end
  end

  assign pending_cnt = (W + 1)'(popcount(MAX_N'(pending)));

endmodule
